gcd_cmp_sub_unit: RTL and testbench
===================================

Name: gcd_cmp_sub_unit

Overview:
- Registered compare-and-subtract datapath for the iterative GCD engine. It combines an unsigned WIDTH-bit magnitude comparator with two ripple-borrow subtractors.
- Each accepted operand pair (a, b) produces gt/eq/lt, both differences (a-b and b-a), their borrows, and zero flags for each operand.
- The GCD control FSM sits above this unit. It uses gt/lt to choose which operand to replace with which difference, and eq/zero flags to detect termination.

Parameters:
- WIDTH, 32, operand and difference width in bits (minimum 2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  captures a/b on this clock edge.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result registers updated on previous edge.
- gt  out  1  a > b.
- eq  out  1  a == b.
- lt  out  1  a < b.
- diff_ab  out  WIDTH  (a - b) mod 2^WIDTH.
- diff_ba  out  WIDTH  (b - a) mod 2^WIDTH.
- borrow_ab  out  1  borrow out of a-b (1 iff a < b).
- borrow_ba  out  1  borrow out of b-a (1 iff b < a).
- a_zero  out  1  a == 0.
- b_zero  out  1  b == 0.

Behaviour:
- Reset (rst low, asynchronous, any time, including mid-operation):
  - All outputs clear to 0 immediately, including gt/eq/lt and out_valid.
  - While rst is low, in_valid is ignored.
  - The first capture happens on the first rising clk edge with rst high and in_valid high.
- Capture:
  - On a rising clk edge with in_valid=1, compute all results combinationally from a/b and register them.
  - out_valid is set to 1 for exactly the cycle after each capture.
  - Latency is 1 cycle. Throughput is 1 pair per cycle; back-to-back in_valid is legal.
- Hold: on an edge with in_valid=0, out_valid goes 0 and all other outputs keep their last captured values.
- Comparator:
  - Unsigned, evaluated MSB-first; the first differing bit decides gt or lt.
  - eq only if all bits match.
  - After any capture, exactly one of gt/eq/lt is 1.
- Subtractors:
  - WIDTH chained 1-bit full subtractors, borrow-in 0 at the LSB.
  - diff = x - y - bin; bout = (~x & y) | (~(x ^ y) & bin).
  - Results wrap modulo 2^WIDTH; there is no saturation.
  - Both subtractors always compute, independent of the compare result.
- Consistency (must hold on every captured result):
  - borrow_ab == lt and borrow_ba == gt.
  - eq implies diff_ab == diff_ba == 0 and both borrows are 0.
  - diff_ab + diff_ba == 0 mod 2^WIDTH.
- Zero flags:
  - Derived directly from the operands, independent of the comparator.
  - a=b=0 gives eq=1, a_zero=1, b_zero=1; this is legal here, and flagging it as an error is the FSM's job.
- There are no X/Z outputs after reset.

Test Plan:
- Reset then idle: hold rst=0, then release with in_valid=0 → all outputs 0, out_valid stays 0.
- a=48, b=18, in_valid 1 cycle → next cycle:
  - out_valid=1, gt=1, eq=0, lt=0.
  - diff_ab=30, diff_ba=0xFFFFFFE2, borrow_ab=0, borrow_ba=1, a_zero=0, b_zero=0.
  - Following cycle: out_valid=0 with other values held.
- a=7, b=7 → eq=1, diff_ab=0, diff_ba=0, both borrows 0. Then a=0, b=5 → lt=1, diff_ab=0xFFFFFFFB, diff_ba=5, borrow_ab=1, a_zero=1.
- Extremes:
  - a=0xFFFFFFFF, b=0 → gt=1, diff_ab=0xFFFFFFFF, diff_ba=1, b_zero=1.
  - a=0x80000000, b=0x7FFFFFFF → gt=1 (unsigned), diff_ab=1.
  - a=b=0 → eq=1, a_zero=1, b_zero=1.
- Back-to-back pairs (48,18), (30,18), (12,18), (12,6), (6,6) on consecutive cycles:
  - out_valid=1 for 5 consecutive cycles.
  - Results in order: gt/30, gt/12, lt/diff_ba=6, gt/6, eq/0.
- Reset mid-stream: assert rst low between clock edges during back-to-back captures → outputs clear to 0 immediately, without waiting for clk. After release, the next captured pair produces correct results one cycle later.

Source files
------------

// File: rtl/gcd_cmp_sub_unit.sv
// Registered compare-and-subtract datapath for the iterative GCD engine.
// Provides an MSB-first magnitude compare, both ripple-borrow differences and operand zero flags.
module gcd_cmp_sub_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] diff_ab,
  output logic [WIDTH-1:0] diff_ba,
  output logic             borrow_ab,
  output logic             borrow_ba,
  output logic             a_zero,
  output logic             b_zero
);

  // Result of one ripple-borrow subtraction: borrow-out in the MSB, difference below it.
  typedef struct packed {
    logic             bout;
    logic [WIDTH-1:0] diff;
  } sub_result_t;

  // Result of the magnitude comparison; exactly one field is set.
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_result_t;

  // Chain of 1-bit full subtractors with zero borrow-in at the LSB.
  function automatic sub_result_t ripple_sub(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    sub_result_t r;
    logic        bin;
    r   = '0;
    bin = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      r.diff[i] = x[i] ^ y[i] ^ bin;
      bin       = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bin);
    end
    r.bout = bin;
    return r;
  endfunction

  // Scan from the MSB; the first differing bit settles the ordering.
  function automatic cmp_result_t mag_compare(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    cmp_result_t c;
    logic        decided;
    c       = '0;
    decided = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!decided && (x[i] != y[i])) begin
        decided = 1'b1;
        c.gt    = x[i];
        c.lt    = y[i];
      end
    end
    c.eq = ~decided;
    return c;
  endfunction

  cmp_result_t cmp_next;
  sub_result_t sub_ab_next;
  sub_result_t sub_ba_next;
  logic        a_zero_next;
  logic        b_zero_next;

  always_comb begin
    cmp_next    = mag_compare(a, b);
    sub_ab_next = ripple_sub(a, b);
    sub_ba_next = ripple_sub(b, a);
    a_zero_next = (a == '0);
    b_zero_next = (b == '0);
  end

  // Results are only refreshed on a capture; otherwise they hold for the control FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      diff_ab   <= '0;
      diff_ba   <= '0;
      borrow_ab <= 1'b0;
      borrow_ba <= 1'b0;
      a_zero    <= 1'b0;
      b_zero    <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt        <= cmp_next.gt;
        eq        <= cmp_next.eq;
        lt        <= cmp_next.lt;
        diff_ab   <= sub_ab_next.diff;
        diff_ba   <= sub_ba_next.diff;
        borrow_ab <= sub_ab_next.bout;
        borrow_ba <= sub_ba_next.bout;
        a_zero    <= a_zero_next;
        b_zero    <= b_zero_next;
      end
    end
  end

endmodule

// File: tb/tb_gcd_cmp_sub_unit.sv
// Directed bench for gcd_cmp_sub_unit: hand-computed vectors, immediate assertions per step.
module tb_gcd_cmp_sub_unit;

  localparam int WIDTH = 32;
  localparam int OBSW  = 8 + 2 * WIDTH;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             gt;
  logic             eq;
  logic             lt;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;
  logic             borrow_ab;
  logic             borrow_ba;
  logic             a_zero;
  logic             b_zero;

  int checks = 0;
  int errors = 0;

  gcd_cmp_sub_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .gt        (gt),
    .eq        (eq),
    .lt        (lt),
    .diff_ab   (diff_ab),
    .diff_ba   (diff_ba),
    .borrow_ab (borrow_ab),
    .borrow_ba (borrow_ba),
    .a_zero    (a_zero),
    .b_zero    (b_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [OBSW-1:0] observed;
  assign observed = {out_valid, gt, eq, lt, diff_ab, diff_ba,
                     borrow_ab, borrow_ba, a_zero, b_zero};

  // Drive one input set at a falling edge and wait until the next falling edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic v);
    a        = av;
    b        = bv;
    in_valid = v;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic ov, input logic egt,
                             input logic eeq, input logic elt,
                             input logic [WIDTH-1:0] dab, input logic [WIDTH-1:0] dba,
                             input logic bab, input logic bba,
                             input logic az, input logic bz);
    logic [OBSW-1:0] expected;
    expected = {ov, egt, eeq, elt, dab, dba, bab, bba, az, bz};
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    #1;
    checkOutput("reset", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(32'd0, 32'd0, 1'b0);
    checkOutput("idle_after_reset", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    applyStimulus(32'd48, 32'd18, 1'b1);
    checkOutput("48_18", 1, 1, 0, 0, 32'd30, 32'hFFFFFFE2, 0, 1, 0, 0);
    applyStimulus(32'd99, 32'd99, 1'b0);
    checkOutput("hold_48_18", 0, 1, 0, 0, 32'd30, 32'hFFFFFFE2, 0, 1, 0, 0);

    applyStimulus(32'd7, 32'd7, 1'b1);
    checkOutput("7_7", 1, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(32'd0, 32'd5, 1'b1);
    checkOutput("0_5", 1, 0, 0, 1, 32'hFFFFFFFB, 32'd5, 1, 0, 1, 0);

    applyStimulus(32'hFFFFFFFF, 32'h0, 1'b1);
    checkOutput("max_0", 1, 1, 0, 0, 32'hFFFFFFFF, 32'h1, 0, 1, 0, 1);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b1);
    checkOutput("msb_vs_rest", 1, 1, 0, 0, 32'h1, 32'hFFFFFFFF, 0, 1, 0, 0);
    applyStimulus(32'h0, 32'h0, 1'b1);
    checkOutput("0_0", 1, 0, 1, 0, 32'h0, 32'h0, 0, 0, 1, 1);

    applyStimulus(32'd48, 32'd18, 1'b1);
    checkOutput("b2b_48_18", 1, 1, 0, 0, 32'd30, 32'hFFFFFFE2, 0, 1, 0, 0);
    applyStimulus(32'd30, 32'd18, 1'b1);
    checkOutput("b2b_30_18", 1, 1, 0, 0, 32'd12, 32'hFFFFFFF4, 0, 1, 0, 0);
    applyStimulus(32'd12, 32'd18, 1'b1);
    checkOutput("b2b_12_18", 1, 0, 0, 1, 32'hFFFFFFFA, 32'd6, 1, 0, 0, 0);
    applyStimulus(32'd12, 32'd6, 1'b1);
    checkOutput("b2b_12_6", 1, 1, 0, 0, 32'd6, 32'hFFFFFFFA, 0, 1, 0, 0);
    applyStimulus(32'd6, 32'd6, 1'b1);
    checkOutput("b2b_6_6", 1, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    applyStimulus(32'd1, 32'd2, 1'b0);
    checkOutput("b2b_hold", 0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0, 0);

    // Asynchronous reset lands between edges while captures are streaming.
    applyStimulus(32'd48, 32'd18, 1'b1);
    checkOutput("stream_48_18", 1, 1, 0, 0, 32'd30, 32'hFFFFFFE2, 0, 1, 0, 0);
    a = 32'd30;
    b = 32'd18;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clear", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("valid_ignored_in_reset", 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(32'd12, 32'd6, 1'b1);
    checkOutput("after_release_12_6", 1, 1, 0, 0, 32'd6, 32'hFFFFFFFA, 0, 1, 0, 0);
    applyStimulus(32'd0, 32'd0, 1'b0);
    checkOutput("after_release_hold", 0, 1, 0, 0, 32'd6, 32'hFFFFFFFA, 0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
